rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, ROM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, word-address width shared by both requesters and the ROM port.
REQ-003 Parameter CNT_WIDTH, default 16, width of each per-port grant counter.
REQ-004 rawclk  input  1  single clock for all state and for the attached synchronous ROM.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch port requests a read this cycle.
REQ-007 if_addr  input  ADDR_WIDTH  instruction-fetch word address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 if_rvalid  output  1  fetch read data valid (one-cycle pulse).
REQ-010 if_rdata  output  DATA_WIDTH  fetch read data, held stable between responses.
REQ-011 dp_req, dp_addr, dp_gnt, dp_rvalid, dp_rdata  same directions, widths and meanings as REQ-006..010, for the data/debug port.
REQ-012 rom_addr  output  ADDR_WIDTH  address driven to the ROM; sampled by the ROM on the rawclk rising edge.
REQ-013 rom_data  input  DATA_WIDTH  ROM output; valid the cycle after rom_addr is sampled.
REQ-014 if_gnt_cnt, dp_gnt_cnt  output  CNT_WIDTH each  saturating grant counters.

Function
REQ-015 At most one of if_gnt, dp_gnt SHALL be high in any cycle; a grant SHALL only be given to a port whose req is high.
REQ-016 Only one requesting port: that port SHALL be granted in the same cycle.
REQ-017 Both requesting: the port not granted most recently (last-grant pointer) SHALL win; the pointer SHALL update only on a grant.
REQ-018 rom_addr SHALL equal the granted port's address; with no grant it SHALL hold the last granted address.
REQ-019 A grant in cycle N SHALL produce rvalid for that port in cycle N+1 only, with rdata = rom_data of cycle N+1 (latency 1).
REQ-020 The response owner (valid bit + port id) SHALL be registered at grant; a new grant in N+1 SHALL not disturb the N+1 response (back-to-back throughput: one read per cycle).
REQ-021 if_rdata / dp_rdata SHALL be loaded from rom_data only in that port's rvalid cycle and SHALL otherwise hold their value.
REQ-022 The port with no response in a cycle SHALL see rvalid low and unchanged rdata.
REQ-023 Each grant counter SHALL increment by 1 per grant to its port and saturate at 2^CNT_WIDTH-1.
REQ-024 Deasserting req after a grant SHALL not cancel the pending response.
REQ-025 Sustained simultaneous requests SHALL alternate grants strictly (IF, DP, IF, DP...), so neither port starves.

Reset
REQ-026 While rst_n is low: if_rvalid=dp_rvalid=0, if_rdata=dp_rdata=0, rom_addr=0, counters=0, response-owner invalid, last-grant pointer = DP (so IF wins the first contention).
REQ-027 Reset asserted with a response in flight SHALL discard it; no rvalid SHALL appear after reset release without a new grant.
REQ-028 Grants (combinational) SHALL be forced low while rst_n is low.

Verification
REQ-029 Reset release, if_req=1 with if_addr=0x004 in cycle 1 -> if_gnt=1 cycle 1; if_rvalid=1 cycle 2 with if_rdata=ROM[0x004]; dp outputs idle.
REQ-030 Both ports request every cycle for 6 cycles (if_addr=0x010, dp_addr=0x020) -> grants IF,DP,IF,DP,IF,DP; rvalid alternates one cycle later; if_gnt_cnt=3, dp_gnt_cnt=3.
REQ-031 dp grant in cycle N, no requests after -> dp_rdata holds ROM[dp_addr] for 10 further cycles, rom_addr stays at dp_addr.
REQ-032 Grant in cycle N, rst_n pulsed low in cycle N+1 -> no rvalid in N+1 or later, all outputs at reset values.
REQ-033 CNT_WIDTH=4, if_req held high alone for 20 cycles -> if_gnt_cnt reaches 15 and stays at 15.
REQ-034 Randomised requests against a ROM model -> every rvalid carries the word at the address granted one cycle earlier; never two grants in one cycle.

Source files
------------

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : Shares one synchronous single-port ROM between an instruction-
//            fetch (IF) requester and a data/debug (DP) requester.
//            Grants are combinational and round-robin on contention.
//            Read data returns one cycle after the grant, with one read per
//            cycle sustained.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  ROM word width in bits
//   ADDR_WIDTH  word-address width (requesters and ROM port)
//   CNT_WIDTH   width of each saturating per-port grant counter
// Ports
//   rawclk                 single clock (also clocks the attached ROM)
//   rst_n                  asynchronous active-low reset
//   if_req / if_addr       fetch request and word address
//   if_gnt                 fetch request accepted this cycle (combinational)
//   if_rvalid / if_rdata   fetch response pulse and held read data
//   dp_*                   same set of signals for the data/debug port
//   rom_addr               address to the ROM, sampled on rawclk rising edge
//   rom_data               ROM output, valid the cycle after rom_addr sampled
//   if_gnt_cnt/dp_gnt_cnt  saturating grant counters
// ============================================================================
module rom_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rawclk,
  input  logic                  rst_n,
  // instruction-fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // data/debug port
  input  logic                  dp_req,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  output logic                  dp_gnt,
  output logic                  dp_rvalid,
  output logic [DATA_WIDTH-1:0] dp_rdata,
  // ROM port
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  // statistics
  output logic [CNT_WIDTH-1:0]  if_gnt_cnt,
  output logic [CNT_WIDTH-1:0]  dp_gnt_cnt
);

  // Port identifiers used by the last-grant pointer and the response owner.
  localparam logic [0:0] PORT_IF = 1'b0;
  localparam logic [0:0] PORT_DP = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]            last_grant;   // port granted most recently
  logic [ADDR_WIDTH-1:0] addr_hold;    // last granted address
  logic                  resp_valid;   // a response is due this cycle
  logic [0:0]            resp_port;    // owner of that response
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dp_rdata_q;
  logic [CNT_WIDTH-1:0]  if_cnt_q;
  logic [CNT_WIDTH-1:0]  dp_cnt_q;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic if_win;
  logic dp_win;
  logic any_win;

  // Grants are forced low during reset so that nothing is issued to the ROM
  // while the response tracking is being cleared.
  always_comb begin
    if_win = 1'b0;
    dp_win = 1'b0;
    if (rst_n) begin
      if (if_req && dp_req) begin
        // Contention: the port that did not win last time goes now. This
        // gives strict alternation under sustained double requests.
        if_win = (last_grant == PORT_DP);
        dp_win = (last_grant == PORT_IF);
      end else begin
        if_win = if_req;
        dp_win = dp_req;
      end
    end
  end

  assign any_win = if_win | dp_win;
  assign if_gnt  = if_win;
  assign dp_gnt  = dp_win;

  // The ROM samples its address on the same edge that registers the grant,
  // so the address path is combinational from the winning requester. With
  // no grant the previous address is replayed, keeping the ROM output (and
  // anything downstream watching it) stable.
  always_comb begin
    if (if_win) begin
      rom_addr = if_addr;
    end else if (dp_win) begin
      rom_addr = dp_addr;
    end else begin
      rom_addr = addr_hold;
    end
  end

  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_DP;         // IF wins the first contention
      addr_hold  <= '0;
    end else if (any_win) begin
      last_grant <= dp_win ? PORT_DP : PORT_IF;
      addr_hold  <= rom_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Response tracking
  // --------------------------------------------------------------------------
  // The owner is captured at grant time, independent of whether the
  // requester keeps its req asserted. A grant in the response cycle simply
  // overwrites the owner for the following cycle, so back-to-back reads do
  // not interfere.
  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_port  <= PORT_IF;
    end else begin
      resp_valid <= any_win;
      resp_port  <= dp_win ? PORT_DP : PORT_IF;
    end
  end

  assign if_rvalid = resp_valid && (resp_port == PORT_IF);
  assign dp_rvalid = resp_valid && (resp_port == PORT_DP);

  // Read data is the live ROM output during the response cycle and the
  // captured copy afterwards, so each port sees its word in the rvalid cycle
  // itself and keeps it until its next response.
  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
    end else begin
      if (if_rvalid) begin
        if_rdata_q <= rom_data;
      end
      if (dp_rvalid) begin
        dp_rdata_q <= rom_data;
      end
    end
  end

  assign if_rdata = if_rvalid ? rom_data : if_rdata_q;
  assign dp_rdata = dp_rvalid ? rom_data : dp_rdata_q;

  // --------------------------------------------------------------------------
  // Saturating grant counters
  // --------------------------------------------------------------------------
  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) begin
      if_cnt_q <= '0;
      dp_cnt_q <= '0;
    end else begin
      if (if_win && (if_cnt_q != CNT_MAX)) begin
        if_cnt_q <= if_cnt_q + 1'b1;
      end
      if (dp_win && (dp_cnt_q != CNT_MAX)) begin
        dp_cnt_q <= dp_cnt_q + 1'b1;
      end
    end
  end

  assign if_gnt_cnt = if_cnt_q;
  assign dp_gnt_cnt = dp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_port_arbiter
// Purpose  : Self-checking bench for rom_port_arbiter with a behavioural
//            synchronous ROM (one-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 4;

  logic          rawclk;
  logic          rst_n;
  logic          if_req, dp_req;
  logic [AW-1:0] if_addr, dp_addr;
  logic          if_gnt, dp_gnt, if_rvalid, dp_rvalid;
  logic [DW-1:0] if_rdata, dp_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [CW-1:0] if_gnt_cnt, dp_gnt_cnt;

  int checks   = 0;
  int failures = 0;

  rom_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .rawclk     (rawclk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dp_req     (dp_req),
    .dp_addr    (dp_addr),
    .dp_gnt     (dp_gnt),
    .dp_rvalid  (dp_rvalid),
    .dp_rdata   (dp_rdata),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .if_gnt_cnt (if_gnt_cnt),
    .dp_gnt_cnt (dp_gnt_cnt)
  );

  initial rawclk = 1'b0;
  always #5 rawclk = ~rawclk;

  // Distinctive ROM contents: both the address and its complement appear.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, ~a};
  endfunction

  always @(posedge rawclk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          e_igt;
    logic          e_dgt;
    logic          e_irv;
    logic          e_drv;
    logic [AW-1:0] e_raddr;
    logic [DW-1:0] e_ird;
    logic [DW-1:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic [AW-1:0] da,
                         input logic eig, input logic edg,
                         input logic eirv, input logic edrv,
                         input logic [AW-1:0] era,
                         input logic [DW-1:0] eird, input logic [DW-1:0] edrd);
    vec_t v;
    v.ireq = ir;   v.iaddr = ia;  v.dreq = dr;   v.daddr = da;
    v.e_igt = eig; v.e_dgt = edg; v.e_irv = eirv; v.e_drv = edrv;
    v.e_raddr = era; v.e_ird = eird; v.e_drd = edrd;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; dp_req = 1'b0; if_addr = '0; dp_addr = '0;
  endtask

  // Reset with both requests high to confirm grants are suppressed; release
  // lands just after a rising edge so the next negedge is "cycle 1".
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    if_req = 1'b1; dp_req = 1'b1; if_addr = 10'h111; dp_addr = 10'h222;
    @(negedge rawclk);
    chk({tag, ".rst_if_gnt"}, if_gnt, 1'b0);
    chk({tag, ".rst_dp_gnt"}, dp_gnt, 1'b0);
    chk({tag, ".rst_rom_addr"}, rom_addr, '0);
    chk({tag, ".rst_rvalid"}, {if_rvalid, dp_rvalid}, 2'b00);
    chk({tag, ".rst_rdata"}, {if_rdata, dp_rdata}, 64'h0);
    chk({tag, ".rst_cnt"}, {if_gnt_cnt, dp_gnt_cnt}, '0);
    @(posedge rawclk); #1;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge rawclk); #1;
  endtask

  logic          m_last_dp;
  logic          m_pv, m_pdp;
  logic [AW-1:0] m_paddr;
  logic          e_ig, e_dg;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;

    // ------------------------------------------------------------------
    // Table-driven run: reset release, single port, contention, back-to-
    // back, holds, and pointer behaviour after an uncontended IF grant.
    // ------------------------------------------------------------------
    //       ireq  iaddr    dreq  daddr   igt  dgt  irv  drv  rom_addr  if_rdata             dp_rdata
    add_vec(1'b1, 10'h004, 1'b0, 10'h000, 1'b1,1'b0,1'b0,1'b0, 10'h004, 32'h0,               32'h0);
    add_vec(1'b0, 10'h000, 1'b0, 10'h000, 1'b0,1'b0,1'b1,1'b0, 10'h004, rom_word(10'h004),   32'h0);
    add_vec(1'b1, 10'h010, 1'b1, 10'h020, 1'b0,1'b1,1'b0,1'b0, 10'h020, rom_word(10'h004),   32'h0);
    add_vec(1'b1, 10'h010, 1'b1, 10'h020, 1'b1,1'b0,1'b0,1'b1, 10'h010, rom_word(10'h004),   rom_word(10'h020));
    add_vec(1'b0, 10'h000, 1'b1, 10'h030, 1'b0,1'b1,1'b1,1'b0, 10'h030, rom_word(10'h010),   rom_word(10'h020));
    add_vec(1'b0, 10'h000, 1'b1, 10'h031, 1'b0,1'b1,1'b0,1'b1, 10'h031, rom_word(10'h010),   rom_word(10'h030));
    add_vec(1'b0, 10'h000, 1'b0, 10'h000, 1'b0,1'b0,1'b0,1'b1, 10'h031, rom_word(10'h010),   rom_word(10'h031));
    add_vec(1'b0, 10'h000, 1'b0, 10'h000, 1'b0,1'b0,1'b0,1'b0, 10'h031, rom_word(10'h010),   rom_word(10'h031));
    add_vec(1'b1, 10'h3FF, 1'b0, 10'h000, 1'b1,1'b0,1'b0,1'b0, 10'h3FF, rom_word(10'h010),   rom_word(10'h031));
    add_vec(1'b1, 10'h001, 1'b1, 10'h002, 1'b0,1'b1,1'b1,1'b0, 10'h002, rom_word(10'h3FF),   rom_word(10'h031));
    add_vec(1'b0, 10'h000, 1'b0, 10'h000, 1'b0,1'b0,1'b0,1'b1, 10'h002, rom_word(10'h3FF),   rom_word(10'h002));

    do_reset("tbl");
    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
      dp_req = vecs[i].dreq; dp_addr = vecs[i].daddr;
      @(negedge rawclk);
      chk($sformatf("vec%0d.if_gnt", i),    if_gnt,    vecs[i].e_igt);
      chk($sformatf("vec%0d.dp_gnt", i),    dp_gnt,    vecs[i].e_dgt);
      chk($sformatf("vec%0d.if_rvalid", i), if_rvalid, vecs[i].e_irv);
      chk($sformatf("vec%0d.dp_rvalid", i), dp_rvalid, vecs[i].e_drv);
      chk($sformatf("vec%0d.rom_addr", i),  rom_addr,  vecs[i].e_raddr);
      chk($sformatf("vec%0d.if_rdata", i),  if_rdata,  vecs[i].e_ird);
      chk($sformatf("vec%0d.dp_rdata", i),  dp_rdata,  vecs[i].e_drd);
      next_cycle();
    end
    @(negedge rawclk);
    chk("tbl.if_gnt_cnt", if_gnt_cnt, 4'd3);
    chk("tbl.dp_gnt_cnt", dp_gnt_cnt, 4'd4);

    // ------------------------------------------------------------------
    // Sustained contention: strict alternation starting with IF.
    // ------------------------------------------------------------------
    do_reset("alt");
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        if_req = 1'b1; if_addr = 10'h010; dp_req = 1'b1; dp_addr = 10'h020;
      end else begin
        idle_inputs();
      end
      @(negedge rawclk);
      chk($sformatf("alt%0d.gnt", k), {if_gnt, dp_gnt},
          (k == 6) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01));
      chk($sformatf("alt%0d.rvalid", k), {if_rvalid, dp_rvalid},
          (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b10 : 2'b01));
      if (k > 0 && (k - 1) % 2 == 0) chk($sformatf("alt%0d.if_rdata", k), if_rdata, rom_word(10'h010));
      if (k > 0 && (k - 1) % 2 == 1) chk($sformatf("alt%0d.dp_rdata", k), dp_rdata, rom_word(10'h020));
      next_cycle();
    end
    @(negedge rawclk);
    chk("alt.if_gnt_cnt", if_gnt_cnt, 4'd3);
    chk("alt.dp_gnt_cnt", dp_gnt_cnt, 4'd3);

    // ------------------------------------------------------------------
    // Single DP read followed by 10 idle cycles: data and address hold.
    // ------------------------------------------------------------------
    do_reset("hold");
    dp_req = 1'b1; dp_addr = 10'h1A5;
    @(negedge rawclk);
    chk("hold.dp_gnt", dp_gnt, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge rawclk);
    chk("hold.dp_rvalid", dp_rvalid, 1'b1);
    chk("hold.dp_rdata0", dp_rdata, rom_word(10'h1A5));
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge rawclk);
      chk($sformatf("hold%0d.dp_rdata", k), dp_rdata, rom_word(10'h1A5));
      chk($sformatf("hold%0d.rom_addr", k), rom_addr, 10'h1A5);
      chk($sformatf("hold%0d.rvalid", k), {if_rvalid, dp_rvalid}, 2'b00);
      next_cycle();
    end

    // ------------------------------------------------------------------
    // Reset pulse while a response is in flight discards it.
    // ------------------------------------------------------------------
    do_reset("rip");
    if_req = 1'b1; if_addr = 10'h055;
    @(negedge rawclk);
    chk("rip.if_gnt", if_gnt, 1'b1);
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge rawclk);
    chk("rip.rvalid_in_rst", {if_rvalid, dp_rvalid}, 2'b00);
    chk("rip.rdata_in_rst", {if_rdata, dp_rdata}, 64'h0);
    chk("rip.rom_addr_in_rst", rom_addr, '0);
    chk("rip.cnt_in_rst", {if_gnt_cnt, dp_gnt_cnt}, '0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge rawclk);
      chk($sformatf("rip%0d.rvalid_after", k), {if_rvalid, dp_rvalid}, 2'b00);
      chk($sformatf("rip%0d.if_rdata_after", k), if_rdata, '0);
      next_cycle();
    end

    // ------------------------------------------------------------------
    // Counter saturation at 15 with a 4-bit counter.
    // ------------------------------------------------------------------
    do_reset("sat");
    for (int k = 0; k < 20; k++) begin
      if_req = 1'b1; if_addr = 10'(k);
      @(negedge rawclk);
      if (k == 15) chk("sat.cnt_at15", if_gnt_cnt, 4'd15);
      next_cycle();
    end
    idle_inputs();
    @(negedge rawclk);
    chk("sat.cnt_final", if_gnt_cnt, 4'd15);
    chk("sat.dp_cnt", dp_gnt_cnt, 4'd0);
    next_cycle();

    // ------------------------------------------------------------------
    // Random traffic against a reference arbiter and the ROM model.
    // ------------------------------------------------------------------
    do_reset("rnd");
    m_last_dp = 1'b1; m_pv = 1'b0; m_pdp = 1'b0; m_paddr = '0;
    for (int k = 0; k < 300; k++) begin
      if_req  = 1'($urandom_range(0, 1));
      dp_req  = 1'($urandom_range(0, 1));
      if_addr = AW'($urandom);
      dp_addr = AW'($urandom);
      @(negedge rawclk);
      if (if_req && dp_req) begin
        e_ig = m_last_dp; e_dg = ~m_last_dp;
      end else begin
        e_ig = if_req; e_dg = dp_req;
      end
      chk($sformatf("rnd%0d.gnt", k), {if_gnt, dp_gnt}, {e_ig, e_dg});
      chk($sformatf("rnd%0d.rvalid", k), {if_rvalid, dp_rvalid},
          {m_pv && !m_pdp, m_pv && m_pdp});
      if (m_pv && !m_pdp) chk($sformatf("rnd%0d.if_rdata", k), if_rdata, rom_word(m_paddr));
      if (m_pv &&  m_pdp) chk($sformatf("rnd%0d.dp_rdata", k), dp_rdata, rom_word(m_paddr));
      if (e_ig) chk($sformatf("rnd%0d.rom_addr_if", k), rom_addr, if_addr);
      if (e_dg) chk($sformatf("rnd%0d.rom_addr_dp", k), rom_addr, dp_addr);
      m_pv = e_ig | e_dg;
      m_pdp = e_dg;
      if (e_ig) m_paddr = if_addr;
      if (e_dg) m_paddr = dp_addr;
      if (e_ig | e_dg) m_last_dp = e_dg;
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
